// File: rtl/alu_share_arbiter.sv
// Two-port arbiter sharing one ALU: accept one request, compute, return a tagged registered result.
// Build option: define ALU_SHARE_RR_EN for round-robin tie-breaking (default is fixed priority to port 0).
module alu_share_arbiter #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_req0_valid,
   output logic             o_req0_ready,
   input  logic [2:0]       i_req0_ctrl,
   input  logic [WIDTH-1:0] i_req0_a,
   input  logic [WIDTH-1:0] i_req0_b,
   input  logic             i_req1_valid,
   output logic             o_req1_ready,
   input  logic [2:0]       i_req1_ctrl,
   input  logic [WIDTH-1:0] i_req1_a,
   input  logic [WIDTH-1:0] i_req1_b,
   output logic             o_rsp_valid,
   input  logic             i_rsp_ready,
   output logic             o_rsp_id,
   output logic [WIDTH-1:0] o_rsp_result,
   output logic             o_rsp_zero
);

   localparam int unsigned CTRL_W = 3;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic                w_accept;
   logic                w_grant_id;
   logic                w_tie_id;
   logic                w_any_valid;
   logic [CTRL_W-1:0]   r_ctrl;
   logic [WIDTH-1:0]    r_a;
   logic [WIDTH-1:0]    r_b;
   logic                r_id;
   logic [WIDTH-1:0]    r_result;
   logic                r_zero;
   logic                r_rsp_valid;
   logic [WIDTH-1:0]    w_alu;

   // Tie-break winner when both requesters are valid
`ifdef ALU_SHARE_RR_EN
   logic r_last;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_last <= 1'b1;
      end else if (w_accept) begin
         r_last <= w_grant_id;
      end
   end

   always_comb begin
      w_tie_id = ~r_last;
   end
`else
   always_comb begin
      w_tie_id = 1'b0;
   end
`endif

   always_comb begin
      w_any_valid = i_req0_valid | i_req1_valid;
      w_grant_id  = (i_req0_valid && i_req1_valid) ? w_tie_id : i_req1_valid;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_accept     = 1'b0;
      o_req0_ready = 1'b0;
      o_req1_ready = 1'b0;
      case (r_state)
         IDLE: begin
            if (!rst && w_any_valid) begin
               w_accept     = 1'b1;
               o_req0_ready = ~w_grant_id;
               o_req1_ready = w_grant_id;
               w_state_nxt  = EXEC;
            end
         end
         EXEC: w_state_nxt = RESP;
         RESP: begin
            if (i_rsp_ready) begin
               w_state_nxt = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // Operands are captured only at accept so requesters may change them afterwards
   always_ff @(posedge clk) begin
      if (rst) begin
         r_ctrl <= '0;
         r_a    <= '0;
         r_b    <= '0;
         r_id   <= 1'b0;
      end else if (w_accept) begin
         r_ctrl <= w_grant_id ? i_req1_ctrl : i_req0_ctrl;
         r_a    <= w_grant_id ? i_req1_a    : i_req0_a;
         r_b    <= w_grant_id ? i_req1_b    : i_req0_b;
         r_id   <= w_grant_id;
      end
   end

   always_comb begin
      w_alu = '0;
      case (r_ctrl)
         3'b000:  w_alu = r_a + r_b;
         3'b001:  w_alu = r_a - r_b;
         3'b010:  w_alu = r_a & r_b;
         3'b011:  w_alu = r_a | r_b;
         3'b101:  w_alu = WIDTH'($signed(r_a) < $signed(r_b));
         default: w_alu = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_result    <= '0;
         r_zero      <= 1'b0;
         r_rsp_valid <= 1'b0;
      end else begin
         if (r_state == EXEC) begin
            r_result <= w_alu;
            r_zero   <= (w_alu == '0);
         end
         r_rsp_valid <= (w_state_nxt == RESP);
      end
   end

   assign o_rsp_valid  = r_rsp_valid;
   assign o_rsp_id     = r_id;
   assign o_rsp_result = r_result;
   assign o_rsp_zero   = r_zero;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Randomized + directed scoreboard bench for alu_share_arbiter against a behavioural model.
module tb_alu_share_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        i_req0_valid, i_req1_valid;
   logic        o_req0_ready, o_req1_ready;
   logic [2:0]  i_req0_ctrl, i_req1_ctrl;
   logic [31:0] i_req0_a, i_req0_b, i_req1_a, i_req1_b;
   logic        o_rsp_valid, i_rsp_ready, o_rsp_id, o_rsp_zero;
   logic [31:0] o_rsp_result;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic        id;
      logic [31:0] res;
      logic        zero;
   } exp_t;

   exp_t exp_q[$];

   // Model state: 0 = free, 1 = computing, 2 = presenting result
   int   m_phase = 0;
   logic m_last  = 1'b1;
   logic mon_flush = 1'b0;
   logic mon_held  = 1'b0;
   exp_t mon_cur;

   always #5 clk = ~clk;

   alu_share_arbiter #(.WIDTH(32)) dut (
      .clk          (clk),
      .rst          (rst),
      .i_req0_valid (i_req0_valid),
      .o_req0_ready (o_req0_ready),
      .i_req0_ctrl  (i_req0_ctrl),
      .i_req0_a     (i_req0_a),
      .i_req0_b     (i_req0_b),
      .i_req1_valid (i_req1_valid),
      .o_req1_ready (o_req1_ready),
      .i_req1_ctrl  (i_req1_ctrl),
      .i_req1_a     (i_req1_a),
      .i_req1_b     (i_req1_b),
      .o_rsp_valid  (o_rsp_valid),
      .i_rsp_ready  (i_rsp_ready),
      .o_rsp_id     (o_rsp_id),
      .o_rsp_result (o_rsp_result),
      .o_rsp_zero   (o_rsp_zero)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] ref_alu(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb, r;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      r  = 0;
      case (c)
         3'd0: r = (longint'(a) + longint'(b)) % 64'h1_0000_0000;
         3'd1: r = (longint'(a) + 64'h1_0000_0000 - longint'(b)) % 64'h1_0000_0000;
         3'd2: r = longint'(a & b);
         3'd3: r = longint'(a | b);
         3'd5: r = (sa < sb) ? 1 : 0;
         default: r = 0;
      endcase
      return 32'(r);
   endfunction

   // One clock of stimulus: inputs already driven at the negedge; check and advance the model.
   task automatic tick();
      logic g_any, g_id;
      exp_t e;
      #1;
      g_any = 1'b0;
      g_id  = 1'b0;
      if (!rst && m_phase == 0 && (i_req0_valid || i_req1_valid)) begin
         g_any = 1'b1;
         if (i_req0_valid && i_req1_valid) begin
`ifdef ALU_SHARE_RR_EN
            g_id = ~m_last;
`else
            g_id = 1'b0;
`endif
         end else begin
            g_id = i_req1_valid;
         end
      end
      chk("req0_ready", 32'(o_req0_ready), 32'(g_any && !g_id));
      chk("req1_ready", 32'(o_req1_ready), 32'(g_any && g_id));
      chk("rsp_valid", 32'(o_rsp_valid), 32'(m_phase == 2));
      if (rst) begin
         if (m_phase != 0) begin
            exp_q.delete();
            mon_flush = 1'b1;
         end
         m_phase = 0;
         m_last  = 1'b1;
      end else begin
         case (m_phase)
            0: if (g_any) begin
               e.id   = g_id;
               e.res  = g_id ? ref_alu(i_req1_ctrl, i_req1_a, i_req1_b)
                             : ref_alu(i_req0_ctrl, i_req0_a, i_req0_b);
               e.zero = (e.res == 32'd0);
               exp_q.push_back(e);
               m_last  = g_id;
               m_phase = 1;
            end
            1: m_phase = 2;
            default: if (i_rsp_ready) m_phase = 0;
         endcase
      end
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) begin
         i_req0_valid = 1'b0;
         i_req1_valid = 1'b0;
         i_rsp_ready  = 1'b1;
         rst          = 1'b0;
         tick();
      end
   endtask

   task automatic issue(input logic port, input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
      rst         = 1'b0;
      i_rsp_ready = 1'b1;
      i_req0_valid = !port; i_req0_ctrl = c; i_req0_a = a; i_req0_b = b;
      i_req1_valid = port;  i_req1_ctrl = c; i_req1_a = a; i_req1_b = b;
      tick();
      idle(3);
   endtask

   function automatic logic [31:0] rand_op();
      case ($urandom_range(0, 5))
         0: return 32'd0;
         1: return 32'hFFFF_FFFF;
         2: return 32'h8000_0000;
         3: return 32'($urandom_range(0, 15));
         default: return $urandom;
      endcase
   endfunction

   // Monitor: pop an expectation when a result first appears, verify it is held until handshake
   initial begin
      forever begin
         @(posedge clk);
         if (mon_flush) begin
            mon_held  = 1'b0;
            mon_flush = 1'b0;
         end else if (mon_held && i_rsp_ready) begin
            mon_held = 1'b0;
         end
         #1;
         if (o_rsp_valid) begin
            if (!mon_held) begin
               chk("rsp_expected_pending", 32'(exp_q.size() != 0), 32'd1);
               if (exp_q.size() != 0) begin
                  mon_cur  = exp_q.pop_front();
                  mon_held = 1'b1;
               end
            end
            if (mon_held) begin
               chk("rsp_id", 32'(o_rsp_id), 32'(mon_cur.id));
               chk("rsp_result", o_rsp_result, mon_cur.res);
               chk("rsp_zero", 32'(o_rsp_zero), 32'(mon_cur.zero));
            end
         end
      end
   end

   initial begin
      rst = 1'b1;
      i_rsp_ready = 1'b0;
      i_req0_valid = 1'b0; i_req0_ctrl = '0; i_req0_a = '0; i_req0_b = '0;
      i_req1_valid = 1'b1; i_req1_ctrl = '0; i_req1_a = '0; i_req1_b = '0;
      @(negedge clk);
      tick();
      tick();
      rst = 1'b0;
      i_req1_valid = 1'b0;
      #1;
      chk("reset_rsp_valid", 32'(o_rsp_valid), 32'd0);
      chk("reset_rsp_id", 32'(o_rsp_id), 32'd0);
      chk("reset_rsp_result", o_rsp_result, 32'd0);
      chk("reset_rsp_zero", 32'(o_rsp_zero), 32'd0);
      @(negedge clk);

      issue(1'b0, 3'b000, 32'd5, 32'd7);
      issue(1'b0, 3'b001, 32'd9, 32'd9);
      issue(1'b1, 3'b001, 32'd0, 32'd1);
      issue(1'b1, 3'b101, 32'hFFFF_FFFF, 32'd1);
      issue(1'b0, 3'b101, 32'd1, 32'hFFFF_FFFF);
      issue(1'b0, 3'b111, 32'd3, 32'd4);
      issue(1'b1, 3'b010, 32'hF0F0_1234, 32'h0FF0_FFFF);
      issue(1'b0, 3'b011, 32'h1200_0000, 32'h0000_0034);

      // Contention: both valid for four operations
      i_req0_valid = 1'b1; i_req0_ctrl = 3'b000; i_req0_a = 32'd100; i_req0_b = 32'd1;
      i_req1_valid = 1'b1; i_req1_ctrl = 3'b001; i_req1_a = 32'd100; i_req1_b = 32'd1;
      i_rsp_ready  = 1'b1;
      for (int k = 0; k < 12; k++) tick();
      idle(2);

      // Backpressure: result held five cycles, no accepts while waiting
      i_req0_valid = 1'b1; i_req0_ctrl = 3'b000; i_req0_a = 32'd40; i_req0_b = 32'd2;
      i_req1_valid = 1'b1;
      i_rsp_ready  = 1'b0;
      for (int k = 0; k < 7; k++) begin
         tick();
         i_req0_a = $urandom;
         i_req1_a = $urandom;
      end
      i_rsp_ready = 1'b1;
      for (int k = 0; k < 4; k++) tick();
      idle(2);

      // Reset during EXEC after a port-0 win, then a tie must go to port 0
      issue(1'b0, 3'b000, 32'd1, 32'd1);
      i_req0_valid = 1'b1; i_req1_valid = 1'b0; i_req0_ctrl = 3'b000;
      tick();
      i_req0_valid = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      i_req0_valid = 1'b1; i_req1_valid = 1'b1;
      i_req0_ctrl = 3'b011; i_req0_a = 32'd6; i_req0_b = 32'd9;
      tick();
      idle(4);

      // Reset while presenting a result
      i_req1_valid = 1'b1; i_req0_valid = 1'b0; i_rsp_ready = 1'b0;
      tick(); tick(); tick();
      rst = 1'b1;
      tick();
      idle(3);

      for (int n = 0; n < 600; n++) begin
         rst          = ($urandom_range(0, 79) == 0);
         i_rsp_ready  = ($urandom_range(0, 3) != 0);
         i_req0_valid = 1'($urandom_range(0, 1));
         i_req1_valid = 1'($urandom_range(0, 1));
         i_req0_ctrl  = 3'($urandom_range(0, 7));
         i_req1_ctrl  = 3'($urandom_range(0, 7));
         i_req0_a = rand_op(); i_req0_b = rand_op();
         i_req1_a = rand_op(); i_req1_b = rand_op();
         tick();
      end
      idle(6);

      chk("drain_queue", 32'(exp_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout checks=%0d", checks);
      $fatal(1, "timeout");
   end

endmodule
